// File: rtl/fre_seq.sv
//==============================================================================
// Module   : fre_seq
// Brief    : Frequency-meter measurement sequencer (clear -> gate -> latch ->
//            report) with selectable gate length, sticky overflow capture and
//            a valid/ready result handshake. Define FRE_CONT_EN to add the
//            `cont` port for continuous back-to-back re-arming.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fre_seq #(
    parameter int GATE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] range,
`ifdef FRE_CONT_EN
    input  logic       cont,
`endif
    input  logic       cnt_ovf,
    input  logic       meas_ready,
    output logic       count_en,
    output logic       count_clr,
    output logic       load,
    output logic       meas_valid,
    output logic       ovf,
    output logic       busy
);

    localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CW-1:0] LEN0_M1 = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] LEN1_M1 = CW'(GATE_CYCLES / 10 - 1);
    localparam logic [CW-1:0] LEN2_M1 = CW'(GATE_CYCLES / 100 - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_LATCH  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CW-1:0]   gate_len_m1;
    logic [1:0]      range_q, range_d;
    logic            sticky_q, sticky_d;
    logic            count_en_q, count_en_d;
    logic            count_clr_q, count_clr_d;
    logic            load_q, load_d;
    logic            meas_valid_q, meas_valid_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            rearm;

`ifdef FRE_CONT_EN
    assign rearm = cont;
`else
    assign rearm = 1'b0;
`endif

    always_comb begin
        case (range_q)
            2'd1:    gate_len_m1 = LEN1_M1;
            2'd2:    gate_len_m1 = LEN2_M1;
            default: gate_len_m1 = LEN0_M1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        range_d    = range_q;
        sticky_d   = sticky_q;

        case (state_q)
            ST_IDLE: begin
                range_d = range;
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                gate_cnt_d = gate_len_m1;
                sticky_d   = 1'b0;
                state_d    = ST_GATE;
            end
            ST_GATE: begin
                sticky_d = sticky_q | cnt_ovf;
                // Counter parks at zero; it is only reloaded in CLEAR.
                if (gate_cnt_q == '0) state_d = ST_LATCH;
                else                  gate_cnt_d = gate_cnt_q - CW'(1);
            end
            ST_LATCH: begin
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                if (meas_ready) state_d = rearm ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) state_d = ST_IDLE;

        // Outputs are the registered decode of the state being entered.
        count_en_d   = (state_d == ST_GATE);
        count_clr_d  = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
        load_d       = (state_d == ST_LATCH);
        meas_valid_d = (state_d == ST_REPORT);
        busy_d       = (state_d != ST_IDLE);
        ovf_d        = 1'b0;
        if (state_d == ST_REPORT)
            ovf_d = (state_q == ST_LATCH) ? sticky_q : ovf_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            gate_cnt_q   <= '0;
            range_q      <= 2'd0;
            sticky_q     <= 1'b0;
            count_en_q   <= 1'b0;
            count_clr_q  <= 1'b1;
            load_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            range_q      <= range_d;
            sticky_q     <= sticky_d;
            count_en_q   <= count_en_d;
            count_clr_q  <= count_clr_d;
            load_q       <= load_d;
            meas_valid_q <= meas_valid_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign count_en   = count_en_q;
    assign count_clr  = count_clr_q;
    assign load       = load_q;
    assign meas_valid = meas_valid_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/fre_seq.md
# fre_seq

Measurement sequencer for the frequency-meter datapath. It drives the gated counter's `count_en`, `count_clr` and `load` controls through clear → gate → latch → report, with selectable gate length, overflow capture and a valid/ready result handshake. It sits between the front-panel/host control logic and the counter/latch/display chain, and replaces free-running toggle gating with a deterministic, abortable sequence.

## Interface
Parameters:
- `GATE_CYCLES`, default 1000: gate length in `clk` cycles for range 0. Must be a multiple of 100 and ≥ 100.

Ports:
- `clk` in 1: reference clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled request to begin a measurement; honoured only in IDLE.
- `abort` in 1: cancels any measurement; takes effect on the next edge.
- `range` in 2: gate select, captured on start. 0 → `GATE_CYCLES`, 1 → `GATE_CYCLES/10`, 2 → `GATE_CYCLES/100`, 3 → treated as 0.
- `cont` in 1: continuous re-arm request; present only with `FRE_CONT_EN`.
- `cnt_ovf` in 1: overflow flag from the counter, sampled during GATE.
- `meas_ready` in 1: downstream accepts the result.
- `count_en` out 1: counter enable.
- `count_clr` out 1: counter synchronous clear.
- `load` out 1: one-cycle latch strobe to the result register.
- `meas_valid` out 1: result latched and awaiting `meas_ready`.
- `ovf` out 1: the latched result overflowed; valid while `meas_valid`=1.
- `busy` out 1: high in every state except IDLE.

## Operation
- States are IDLE, CLEAR, GATE, LATCH and REPORT. All outputs are registered Moore decodes of the state.
- **IDLE:** `count_clr`=1 and all other outputs are 0.
  - `start`=1 → CLEAR.
  - `range` is captured into `range_q`.
- **CLEAR:** lasts 1 cycle.
  - `count_clr`=1.
  - The gate counter loads `gate_len-1`.
  - The sticky overflow flag is cleared.
  - → GATE.
- **GATE:** `count_en`=1 and `count_clr`=0.
  - The gate counter decrements each cycle.
  - The sticky flag ORs in `cnt_ovf`.
  - When the counter equals 0 → LATCH. `count_en` is therefore high for exactly `gate_len` cycles.
- **LATCH:** lasts 1 cycle.
  - `load`=1 and `count_en`=0.
  - `ovf` ← sticky flag.
  - → REPORT.
- **REPORT:** `meas_valid`=1 and `ovf` is held.
  - On `meas_valid && meas_ready` → IDLE, or → CLEAR when re-arming (see Configuration).
- **Gate counter:** width `$clog2(GATE_CYCLES)`.
  - `gate_len` is computed from `range_q` only; changing `range` mid-measurement has no effect.
  - There is no wrap: the counter is reloaded only in CLEAR.
- **`abort`:** from any state → IDLE on the next edge.
  - `meas_valid`, `ovf`, `load` and `count_en` drop to 0 in that cycle.
  - `abort` has priority over `start`, `meas_ready` and gate expiry.
- **`start` while busy:** ignored; it is not queued.
- **`cnt_ovf` outside GATE:** ignored.
- **`cnt_ovf` in the last GATE cycle:** captured.

## Timing
- **Reset values (rst=0):**
  - State is IDLE.
  - `count_clr`=1.
  - `count_en`, `load`, `meas_valid`, `ovf` and `busy` are 0.
  - `range_q`=0 and the gate counter is 0.
- **Start sequence:** `start` sampled high at edge N gives:
  - CLEAR in cycle N+1.
  - `count_en` high in cycles N+2 … N+1+`gate_len`.
  - `load` in cycle N+2+`gate_len`.
  - `meas_valid` from cycle N+3+`gate_len`.
- **Handshake:** `meas_valid` stays high until the edge on which `meas_ready`=1. It deasserts on the following cycle.
- **Ready held high early:** if `meas_ready` is already high, REPORT lasts exactly 1 cycle.
- **Minimum idle-to-idle time:** `gate_len`+4 cycles.
- **Reset mid-operation:** reset asserted at any point forces the reset values immediately, asynchronously. The first `start` is sampled on the first edge after rst=1.

## Configuration
- **`FRE_CONT_EN` defined:**
  - The `cont` port exists.
  - A REPORT handshake with `cont`=1 goes directly to CLEAR, with no IDLE cycle and `range_q` retained.
  - `busy` stays high.
  - Back-to-back period is `gate_len`+3 cycles.
- **`FRE_CONT_EN` undefined:**
  - The `cont` port is absent.
  - REPORT always returns to IDLE, so every measurement requires a new `start`.

## Test plan
- Reset, then `start` pulse with `GATE_CYCLES`=1000, range=0 → `count_en` high exactly 1000 cycles, `load` pulse at cycle 1002 after start, `meas_valid`=1 and `ovf`=0.
- range=2 with `meas_ready` tied high → `count_en` high 10 cycles, REPORT lasts 1 cycle, `busy` low at start+14.
- `cnt_ovf` pulsed for 1 cycle at the last GATE cycle → `ovf`=1 with `meas_valid`. The next measurement with no overflow gives `ovf`=0.
- `meas_ready` withheld 50 cycles → `meas_valid` and `ovf` stable for 50 cycles. A `start` asserted during REPORT is ignored, and no CLEAR follows the handshake.
- `abort` asserted mid-GATE (cycle 300), and separately `abort` together with `start` in IDLE → `count_en`=0 and IDLE next cycle, no `load`, no `meas_valid`. Asynchronous reset in GATE → all outputs at reset values immediately.
- With `FRE_CONT_EN`, `cont`=1 and `meas_ready`=1, range=1 → repeating 103-cycle period with `count_en` high 100 cycles each and `busy` held high. Dropping `cont` → return to IDLE after the next handshake.
